gnr_attractor_ctrl: RTL and testbench

- Sequencer for a gene-regulatory-network node array in dual-rail simulation mode: the s0 rail is the slow walker, updating every second step; the s1 rail is the fast walker, updating every step.
- For each initial network state in a programmed range, it initialises all nodes, runs Floyd cycle detection until s0 == s1, then measures the attractor period.
- Results are reported per initial state over a valid/ready handshake.
- Sits between the host/accelerator interface and the node array; drives the node array's reset_nos, start_s0, start_s1 and init_state inputs.

---
 rtl/gnr_attractor_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_gnr_attractor_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl: sequencer for a dual-rail gene-regulatory-network node array.
// For every initial state in [state_first, state_first + state_count) it loads the
// array, runs Floyd cycle detection (slow rail s0 vs fast rail s1) until the rails
// meet, then freezes s0 and steps s1 alone to measure the attractor period.
// Each result is offered on a valid/ready handshake. All outputs are registered.
module gnr_attractor_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N_NODES-1:0] state_first,
    input  logic [N_NODES:0]   state_count,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [CNT_W-1:0]   res_meet,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STEP   = 3'd2,
        S_CHECK  = 3'd3,
        S_PSTEP  = 3'd4,
        S_PCHK   = 3'd5,
        S_REPORT = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [N_NODES-1:0] NODE_ZERO = {N_NODES{1'b0}};
    localparam logic [N_NODES-1:0] NODE_ONE  = {{(N_NODES-1){1'b0}}, 1'b1};
    localparam logic [N_NODES:0]   REM_ZERO  = {(N_NODES+1){1'b0}};
    localparam logic [N_NODES:0]   REM_ONE   = {{N_NODES{1'b0}}, 1'b1};

    // State and datapath registers
    state_t               state_r;
    logic [N_NODES-1:0]   cur_r;
    logic [N_NODES:0]     rem_r;
    logic [CNT_W-1:0]     step_r;
    logic [CNT_W-1:0]     period_r;
    logic [CNT_W-1:0]     meet_r;
    logic [CNT_W-1:0]     per_r;
    logic                 tmo_r;

    // Registered output copies
    logic                 reset_nos_r;
    logic [N_NODES-1:0]   init_state_r;
    logic                 start_s0_r;
    logic                 start_s1_r;
    logic                 res_valid_r;
    logic [N_NODES-1:0]   res_init_r;
    logic                 busy_r;
    logic                 done_r;

    // Next-state values
    state_t               state_s;
    logic [N_NODES-1:0]   cur_s;
    logic [N_NODES:0]     rem_s;
    logic [CNT_W-1:0]     step_s;
    logic [CNT_W-1:0]     period_s;
    logic [CNT_W-1:0]     meet_s;
    logic [CNT_W-1:0]     per_s;
    logic                 tmo_s;

    // Next-state and datapath update; abort overrides every transition
    always_comb begin
        state_s  = state_r;
        cur_s    = cur_r;
        rem_s    = rem_r;
        step_s   = step_r;
        period_s = period_r;
        meet_s   = meet_r;
        per_s    = per_r;
        tmo_s    = tmo_r;
        if (abort) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        cur_s = state_first;
                        rem_s = state_count;
                        if (state_count == REM_ZERO) begin
                            state_s = S_DONE;
                        end else begin
                            state_s = S_LOAD;
                        end
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_LOAD: begin
                    step_s   = CNT_ZERO;
                    period_s = CNT_ZERO;
                    meet_s   = CNT_ZERO;
                    per_s    = CNT_ZERO;
                    tmo_s    = 1'b0;
                    state_s  = S_STEP;
                end
                S_STEP: begin
                    // Saturate rather than wrap; CHECK stops the run at the limit
                    if (step_r != MAX_CNT) begin
                        step_s = step_r + CNT_ONE;
                    end else begin
                        step_s = step_r;
                    end
                    state_s = S_CHECK;
                end
                S_CHECK: begin
                    // Rails can only coincide meaningfully after an even step count
                    if (!step_r[0] && (s0_vec == s1_vec)) begin
                        meet_s  = step_r;
                        state_s = S_PSTEP;
                    end else if (step_r >= MAX_CNT) begin
                        tmo_s   = 1'b1;
                        per_s   = CNT_ZERO;
                        state_s = S_REPORT;
                    end else begin
                        state_s = S_STEP;
                    end
                end
                S_PSTEP: begin
                    if (period_r != MAX_CNT) begin
                        period_s = period_r + CNT_ONE;
                    end else begin
                        period_s = period_r;
                    end
                    state_s = S_PCHK;
                end
                S_PCHK: begin
                    if (s1_vec == s0_vec) begin
                        per_s   = period_r;
                        state_s = S_REPORT;
                    end else if (period_r >= MAX_CNT) begin
                        tmo_s   = 1'b1;
                        per_s   = CNT_ZERO;
                        state_s = S_REPORT;
                    end else begin
                        state_s = S_PSTEP;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        cur_s = cur_r + NODE_ONE;
                        rem_s = rem_r - REM_ONE;
                        if (rem_r == REM_ONE) begin
                            state_s = S_DONE;
                        end else begin
                            state_s = S_LOAD;
                        end
                    end else begin
                        state_s = S_REPORT;
                    end
                end
                S_DONE: begin
                    state_s = S_IDLE;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State/datapath registers; outputs are decoded from the next state so they
    // line up with the state they belong to
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            cur_r        <= NODE_ZERO;
            rem_r        <= REM_ZERO;
            step_r       <= CNT_ZERO;
            period_r     <= CNT_ZERO;
            meet_r       <= CNT_ZERO;
            per_r        <= CNT_ZERO;
            tmo_r        <= 1'b0;
            reset_nos_r  <= 1'b0;
            init_state_r <= NODE_ZERO;
            start_s0_r   <= 1'b0;
            start_s1_r   <= 1'b0;
            res_valid_r  <= 1'b0;
            res_init_r   <= NODE_ZERO;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cur_r        <= cur_s;
            rem_r        <= rem_s;
            step_r       <= step_s;
            period_r     <= period_s;
            meet_r       <= meet_s;
            per_r        <= per_s;
            tmo_r        <= tmo_s;
            reset_nos_r  <= (state_s == S_LOAD);
            init_state_r <= (state_s == S_LOAD) ? cur_s : NODE_ZERO;
            start_s0_r   <= (state_s == S_STEP);
            start_s1_r   <= (state_s == S_STEP) || (state_s == S_PSTEP);
            res_valid_r  <= (state_s == S_REPORT);
            res_init_r   <= cur_s;
            busy_r       <= (state_s != S_IDLE);
            done_r       <= (state_s == S_DONE);
        end
    end

    assign reset_nos   = reset_nos_r;
    assign init_state  = init_state_r;
    assign start_s0    = start_s0_r;
    assign start_s1    = start_s1_r;
    assign res_valid   = res_valid_r;
    assign res_init    = res_init_r;
    assign res_meet    = meet_r;
    assign res_period  = per_r;
    assign res_timeout = tmo_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl with 3-node identity/ring network models.
// Instance a: MAX_STEPS = 1024; instance b: MAX_STEPS = 8 (timeout case).
module tb_gnr_attractor_ctrl;

    typedef struct packed {
        logic [2:0]  init;
        logic [15:0] meet;
        logic [15:0] period;
        logic        tmo;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic ring_mode = 1'b0;

    // Instance a signals
    logic        a_start = 1'b0, a_abort = 1'b0, a_ready = 1'b1;
    logic [2:0]  a_first = 3'd0;
    logic [3:0]  a_count = 4'd0;
    logic        a_rn, a_st0, a_st1, a_valid, a_tmo, a_busy, a_done;
    logic [2:0]  a_init, a_rinit;
    logic [15:0] a_meet, a_period;
    logic [2:0]  a_s0 = 3'd0, a_s1 = 3'd0;
    logic        a_ph = 1'b0;
    res_t        qa[$];

    // Instance b signals
    logic        b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b1;
    logic [2:0]  b_first = 3'd0;
    logic [3:0]  b_count = 4'd0;
    logic        b_rn, b_st0, b_st1, b_valid, b_tmo, b_busy, b_done;
    logic [2:0]  b_init, b_rinit;
    logic [15:0] b_meet, b_period;
    logic [2:0]  b_s0 = 3'd0, b_s1 = 3'd0;
    logic        b_ph = 1'b0;
    res_t        qb[$];

    // Monitor bookkeeping
    int   a_rn_cnt = 0, a_rv_cnt = 0, a_done_cnt = 0, b_done_cnt = 0;
    int   hs_cyc = 0;
    logic hs_load_pend = 1'b0, hs_done_pend = 1'b0, hold = 1'b0;
    res_t snap;

    gnr_attractor_ctrl #(.N_NODES(3), .CNT_W(16), .MAX_STEPS(1024)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .state_first(a_first), .state_count(a_count),
        .reset_nos(a_rn), .init_state(a_init), .start_s0(a_st0), .start_s1(a_st1),
        .s0_vec(a_s0), .s1_vec(a_s1), .res_valid(a_valid), .res_ready(a_ready),
        .res_init(a_rinit), .res_meet(a_meet), .res_period(a_period),
        .res_timeout(a_tmo), .busy(a_busy), .done(a_done)
    );

    gnr_attractor_ctrl #(.N_NODES(3), .CNT_W(16), .MAX_STEPS(8)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .state_first(b_first), .state_count(b_count),
        .reset_nos(b_rn), .init_state(b_init), .start_s0(b_st0), .start_s1(b_st1),
        .s0_vec(b_s0), .s1_vec(b_s1), .res_valid(b_valid), .res_ready(b_ready),
        .res_init(b_rinit), .res_meet(b_meet), .res_period(b_period),
        .res_timeout(b_tmo), .busy(b_busy), .done(b_done)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    function automatic logic [2:0] nxt(input logic ring, input logic [2:0] x);
        return ring ? x + 3'd1 : x;
    endfunction

    // Node array model a: load on reset_nos, slow rail moves on odd steps only
    always @(posedge clk) begin
        if (a_rn) begin
            a_s0 <= a_init; a_s1 <= a_init; a_ph <= 1'b1;
        end else begin
            if (a_st0) begin
                if (a_ph) a_s0 <= nxt(ring_mode, a_s0);
                a_ph <= ~a_ph;
            end
            if (a_st1) a_s1 <= nxt(ring_mode, a_s1);
        end
    end

    // Node array model b: always a ring network
    always @(posedge clk) begin
        if (b_rn) begin
            b_s0 <= b_init; b_s1 <= b_init; b_ph <= 1'b1;
        end else begin
            if (b_st0) begin
                if (b_ph) b_s0 <= nxt(1'b1, b_s0);
                b_ph <= ~b_ph;
            end
            if (b_st1) b_s1 <= nxt(1'b1, b_s1);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] a_outs();
        return {19'd0, a_rn, a_init, a_st0, a_st1, a_valid, a_rinit, a_meet,
                a_period, a_tmo, a_busy, a_done};
    endfunction

    // Monitor a: scoreboard pops, stability, strobe legality, timing relations
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("strobe_excl",
                (a_rn && (a_st0 || a_st1)) || (a_st0 && !a_st1) ||
                ((a_valid || a_done || !a_busy) && (a_rn || a_st0 || a_st1)), 0);
            if (a_valid) a_rv_cnt++;
            if (a_rn) begin
                a_rn_cnt++;
                if (qa.size() > 0) chk("load_init", a_init, qa[0].init);
                if (hs_load_pend) begin
                    chk("load_after_hs", cyc, hs_cyc + 1);
                    hs_load_pend = 1'b0;
                end
            end
            if (a_done) begin
                a_done_cnt++;
                if (hs_done_pend) chk("done_after_hs", cyc, hs_cyc + 1);
                hs_done_pend = 1'b0;
                hs_load_pend = 1'b0;
            end
            if (a_valid && !a_ready) begin
                if (hold) chk("res_stable", {a_rinit, a_meet, a_period, a_tmo}, snap);
                else snap = {a_rinit, a_meet, a_period, a_tmo};
                hold = 1'b1;
            end
            if (a_valid && a_ready) begin
                hold = 1'b0;
                hs_cyc = cyc;
                hs_load_pend = 1'b1;
                hs_done_pend = 1'b1;
                if (qa.size() == 0) begin
                    chk("unexpected_result_a", {a_rinit, a_meet, a_period, a_tmo}, 0);
                end else begin
                    chk("result_a", {a_rinit, a_meet, a_period, a_tmo}, qa.pop_front());
                end
            end
        end
    end

    // Monitor b: scoreboard pops only
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (b_done) b_done_cnt++;
            if (b_valid && b_ready) begin
                if (qb.size() == 0) chk("unexpected_result_b", {b_rinit, b_meet, b_period, b_tmo}, 0);
                else chk("result_b", {b_rinit, b_meet, b_period, b_tmo}, qb.pop_front());
            end
        end
    end

    task automatic run_a(input logic [2:0] first, input logic [3:0] count);
        a_first = first; a_count = count; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic wait_done_a(input int max_cyc);
        int d0;
        int n;
        d0 = a_done_cnt; n = 0;
        while (a_done_cnt == d0 && n < max_cyc) begin @(posedge clk); n++; end
        chk("done_seen_a", a_done_cnt != d0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_neg_a(input int sel, input int max_cyc);
        int n;
        logic hit;
        n = 0; hit = 1'b0;
        while (!hit && n < max_cyc) begin
            @(negedge clk); n++;
            case (sel)
                0: hit = a_valid;
                1: hit = a_st1 && !a_st0;
                default: hit = a_st0;
            endcase
        end
        chk("wait_event", hit, 1);
    endtask

    initial begin
        int d0;
        int rn0;
        int rv0;
        #2 rst = 1'b0;
        #1 chk("reset_outs_a", a_outs(), 0);
        chk("reset_outs_b", {b_rn, b_st0, b_st1, b_valid, b_busy, b_done}, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Identity network, one state
        ring_mode = 1'b0; a_rn_cnt = 0;
        qa.push_back('{3'b101, 16'd2, 16'd1, 1'b0});
        run_a(3'b101, 4'd1);
        wait_done_a(200);
        chk("rn_cnt_identity", a_rn_cnt, 1);
        chk("busy_after_done", a_busy, 0);

        // Ring network, two states
        ring_mode = 1'b1; a_rn_cnt = 0;
        qa.push_back('{3'd0, 16'd16, 16'd8, 1'b0});
        qa.push_back('{3'd1, 16'd16, 16'd8, 1'b0});
        run_a(3'd0, 4'd2);
        wait_done_a(400);
        chk("rn_cnt_ring", a_rn_cnt, 2);

        // Backpressure with wrap of the initial state
        ring_mode = 1'b0; a_ready = 1'b0;
        qa.push_back('{3'd7, 16'd2, 16'd1, 1'b0});
        qa.push_back('{3'd0, 16'd2, 16'd1, 1'b0});
        run_a(3'd7, 4'd2);
        wait_neg_a(0, 200);
        repeat (5) @(posedge clk);
        #1 a_ready = 1'b1;
        wait_done_a(200);

        // Abort during PSTEP (ring keeps PSTEP/PCHK alternating)
        ring_mode = 1'b1;
        run_a(3'd4, 4'd1);
        wait_neg_a(1, 200);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("in_pstep", {a_st0, a_st1}, 2'b01);
        a_abort = 1'b1;
        d0 = a_done_cnt;
        @(posedge clk); #1 a_abort = 1'b0;
        chk("abort_idle", {a_busy, a_rn, a_st0, a_st1, a_valid, a_done}, 0);
        repeat (3) @(posedge clk);
        #1 chk("abort_no_done", a_done_cnt, d0);

        // start and abort together from IDLE: abort wins
        a_start = 1'b1; a_abort = 1'b1; a_first = 3'd1; a_count = 4'd1;
        @(posedge clk); #1 a_start = 1'b0; a_abort = 1'b0;
        chk("start_abort_idle", a_busy, 0);

        // New run after abort
        ring_mode = 1'b0;
        qa.push_back('{3'd2, 16'd2, 16'd1, 1'b0});
        run_a(3'd2, 4'd1);
        wait_done_a(200);

        // Asynchronous reset in the middle of STEP
        ring_mode = 1'b1;
        run_a(3'd3, 4'd1);
        wait_neg_a(2, 200);
        #2 rst = 1'b0;
        #1 chk("async_reset_outs", a_outs(), 0);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", a_busy, 0);

        // Empty run
        rn0 = a_rn_cnt; rv0 = a_rv_cnt;
        run_a(3'd5, 4'd0);
        wait_done_a(20);
        chk("empty_no_load", a_rn_cnt, rn0);
        chk("empty_no_valid", a_rv_cnt, rv0);

        // Instance b: ring network times out at MAX_STEPS = 8
        qb.push_back('{3'd0, 16'd0, 16'd0, 1'b1});
        d0 = b_done_cnt;
        b_first = 3'd0; b_count = 4'd1; b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        rn0 = 0;
        while (b_done_cnt == d0 && rn0 < 200) begin @(posedge clk); rn0++; end
        chk("done_seen_b", b_done_cnt != d0, 1);
        @(posedge clk); #1;

        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
